// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: sequences fetch, decode, execute, memory and write-back
// one instruction at a time and decodes the datapath strobes and mux selects.
module multicycle_ctrl #(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       bcond,
    input  logic       ecall_halt,
    output logic       pc_write,
    output logic       pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       halted
);

    localparam int unsigned CntW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(MEM_WAIT - 1);

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpEcall  = 7'b1110011;

    typedef enum logic [2:0] {
        StIf, StId, StEx, StMem, StWb, StBrTaken, StJump, StHalt
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] wait_q, wait_d;
    logic            last_cnt;

    assign last_cnt = (wait_q == CntLast);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIf;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        pc_write   = 1'b0;
        pc_source  = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = 2'd0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        halted     = 1'b0;

        unique case (state_q)
            StIf: begin
                mem_read = 1'b1;
                if (last_cnt) begin
                    ir_write = 1'b1;
                    state_d  = StId;
                end else begin
                    wait_d = wait_q + CntW'(1);
                end
            end
            StId: begin
                alu_src_b = 2'd1;
                case (opcode)
                    OpEcall: begin
                        if (ecall_halt) begin
                            state_d = StHalt;
                        end else begin
                            pc_write = 1'b1;
                            state_d  = StIf;
                        end
                    end
                    OpJal, OpJalr: state_d = StJump;
                    OpR, OpI, OpLoad, OpStore, OpBranch: state_d = StEx;
                    default: begin
                        pc_write = 1'b1;
                        state_d  = StIf;
                    end
                endcase
            end
            StEx: begin
                alu_src_a = 1'b1;
                case (opcode)
                    OpR: begin
                        alu_op  = 2'd2;
                        state_d = StWb;
                    end
                    OpI: begin
                        alu_src_b = 2'd2;
                        alu_op    = 2'd2;
                        state_d   = StWb;
                    end
                    OpLoad, OpStore: begin
                        alu_src_b = 2'd2;
                        state_d   = StMem;
                    end
                    OpBranch: begin
                        alu_op = 2'd1;
                        if (bcond) begin
                            state_d = StBrTaken;
                        end else begin
                            // ALUOut still holds PC+4 from ID
                            pc_write  = 1'b1;
                            pc_source = 1'b1;
                            state_d   = StIf;
                        end
                    end
                    default: state_d = StIf;
                endcase
            end
            StMem: begin
                i_or_d = 1'b1;
                if (opcode == OpLoad) begin
                    mem_read = 1'b1;
                    if (last_cnt) state_d = StWb;
                end else begin
                    mem_write = 1'b1;
                    if (last_cnt) begin
                        alu_src_b = 2'd1;
                        pc_write  = 1'b1;
                        state_d   = StIf;
                    end
                end
                if (!last_cnt) wait_d = wait_q + CntW'(1);
            end
            StWb: begin
                reg_write  = 1'b1;
                mem_to_reg = (opcode == OpLoad);
                alu_src_b  = 2'd1;
                pc_write   = 1'b1;
                state_d    = StIf;
            end
            StBrTaken: begin
                alu_src_b = 2'd2;
                pc_write  = 1'b1;
                state_d   = StIf;
            end
            StJump: begin
                reg_write = 1'b1;
                alu_src_a = (opcode == OpJalr);
                alu_src_b = 2'd2;
                pc_write  = 1'b1;
                state_d   = StIf;
            end
            StHalt: halted = 1'b1;
            default: state_d = StIf;
        endcase

        if (state_d != state_q) wait_d = '0;

        if (reset) begin
            pc_write   = 1'b0;
            pc_source  = 1'b0;
            i_or_d     = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'd0;
            alu_op     = 2'd0;
            reg_write  = 1'b0;
            mem_to_reg = 1'b0;
            halted     = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: one instance with MEM_WAIT=1, one with MEM_WAIT=3,
// checked cycle by cycle against hand-written control vectors.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [6:0] opcode1 = 7'd0, opcode3 = 7'd0;
    logic bcond = 1'b0, ecall_halt = 1'b0;

    logic pw1, ps1, iod1, mr1, mw1, irw1, a1, rw1, m2r1, h1;
    logic [1:0] b1, op1;
    logic pw3, ps3, iod3, mr3, mw3, irw3, a3, rw3, m2r3, h3;
    logic [1:0] b3, op3;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_WAIT(1)) dut1 (
        .clk(clk), .reset(reset), .opcode(opcode1), .bcond(bcond), .ecall_halt(ecall_halt),
        .pc_write(pw1), .pc_source(ps1), .i_or_d(iod1), .mem_read(mr1), .mem_write(mw1),
        .ir_write(irw1), .alu_src_a(a1), .alu_src_b(b1), .alu_op(op1), .reg_write(rw1),
        .mem_to_reg(m2r1), .halted(h1)
    );

    multicycle_ctrl #(.MEM_WAIT(3)) dut3 (
        .clk(clk), .reset(reset), .opcode(opcode3), .bcond(bcond), .ecall_halt(ecall_halt),
        .pc_write(pw3), .pc_source(ps3), .i_or_d(iod3), .mem_read(mr3), .mem_write(mw3),
        .ir_write(irw3), .alu_src_a(a3), .alu_src_b(b3), .alu_op(op3), .reg_write(rw3),
        .mem_to_reg(m2r3), .halted(h3)
    );

    wire [13:0] v1 = {pw1, ps1, iod1, mr1, mw1, irw1, a1, b1, op1, rw1, m2r1, h1};
    wire [13:0] v3 = {pw3, ps3, iod3, mr3, mw3, irw3, a3, b3, op3, rw3, m2r3, h3};

    // Field order: pc_write pc_source i_or_d mem_read mem_write ir_write a b op rw m2r halted
    function automatic logic [13:0] ctl(input logic pw, input logic ps, input logic iod,
                                        input logic mr, input logic mw, input logic irw,
                                        input logic a, input logic [1:0] b,
                                        input logic [1:0] op, input logic rw,
                                        input logic m2r, input logic h);
        return {pw, ps, iod, mr, mw, irw, a, b, op, rw, m2r, h};
    endfunction

    task automatic check_eq(input string tag, input logic [13:0] got, input logic [13:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // One cycle with reset high; returns at a falling edge with reset low and FSM in IF.
    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_seq(input string tag, input bit use3, input logic [13:0] exp_q[$]);
        foreach (exp_q[i]) begin
            if (i > 0) @(negedge clk);
            #1;
            check_eq($sformatf("%s[%0d]", tag, i + 1), use3 ? v3 : v1, exp_q[i]);
        end
    endtask

    logic [13:0] zero, if1, id0, idpc, if3a, if3b;
    logic [13:0] q[$];

    initial begin
        zero = ctl(0,0,0,0,0,0,0,2'd0,2'd0,0,0,0);
        if1  = ctl(0,0,0,1,0,1,0,2'd0,2'd0,0,0,0);
        id0  = ctl(0,0,0,0,0,0,0,2'd1,2'd0,0,0,0);
        idpc = ctl(1,0,0,0,0,0,0,2'd1,2'd0,0,0,0);
        if3a = ctl(0,0,0,1,0,0,0,2'd0,2'd0,0,0,0);
        if3b = ctl(0,0,0,1,0,1,0,2'd0,2'd0,0,0,0);

        @(negedge clk);
        #1;
        check_eq("reset_outputs", v1, zero);
        check_eq("reset_halted3", v3, zero);

        opcode1 = 7'b0110011;
        do_reset();
        q = '{if1, id0, ctl(0,0,0,0,0,0,1,2'd0,2'd2,0,0,0), idpc | ctl(0,0,0,0,0,0,0,0,0,1,0,0),
              if1};
        run_seq("r_add", 1'b0, q);

        opcode1 = 7'b0010011;
        do_reset();
        q = '{if1, id0, ctl(0,0,0,0,0,0,1,2'd2,2'd2,0,0,0), ctl(1,0,0,0,0,0,0,2'd1,2'd0,1,0,0),
              if1};
        run_seq("i_addi", 1'b0, q);

        opcode1 = 7'b1100011;
        bcond = 1'b1;
        do_reset();
        q = '{if1, id0, ctl(0,0,0,0,0,0,1,2'd0,2'd1,0,0,0), ctl(1,0,0,0,0,0,0,2'd2,2'd0,0,0,0),
              if1};
        run_seq("br_taken", 1'b0, q);

        bcond = 1'b0;
        do_reset();
        q = '{if1, id0, ctl(1,1,0,0,0,0,1,2'd0,2'd1,0,0,0), if1};
        run_seq("br_not", 1'b0, q);

        opcode1 = 7'b1100111;
        do_reset();
        q = '{if1, id0, ctl(1,0,0,0,0,0,1,2'd2,2'd0,1,0,0), if1};
        run_seq("jalr", 1'b0, q);

        opcode1 = 7'b1101111;
        do_reset();
        q = '{if1, id0, ctl(1,0,0,0,0,0,0,2'd2,2'd0,1,0,0), if1};
        run_seq("jal", 1'b0, q);

        opcode1 = 7'b0000000;
        do_reset();
        q = '{if1, idpc, if1};
        run_seq("nop", 1'b0, q);

        opcode1 = 7'b1110011;
        ecall_halt = 1'b0;
        do_reset();
        q = '{if1, idpc, if1};
        run_seq("ecall_go", 1'b0, q);

        ecall_halt = 1'b1;
        do_reset();
        q = '{if1, id0};
        for (int i = 0; i < 20; i++) q.push_back(ctl(0,0,0,0,0,0,0,2'd0,2'd0,0,0,1));
        run_seq("ecall_halt", 1'b0, q);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("halt_in_reset", v1, zero);
        @(negedge clk);
        reset = 1'b0;
        ecall_halt = 1'b0;
        opcode1 = 7'b0000000;
        #1;
        check_eq("halt_restart_if", v1, if1);

        opcode3 = 7'b0000011;
        do_reset();
        q = '{if3a, if3a, if3b, id0, ctl(0,0,0,0,0,0,1,2'd2,2'd0,0,0,0),
              ctl(0,0,1,1,0,0,0,2'd0,2'd0,0,0,0), ctl(0,0,1,1,0,0,0,2'd0,2'd0,0,0,0),
              ctl(0,0,1,1,0,0,0,2'd0,2'd0,0,0,0), ctl(1,0,0,0,0,0,0,2'd1,2'd0,1,1,0), if3a};
        run_seq("load_w3", 1'b1, q);

        opcode3 = 7'b0100011;
        do_reset();
        q = '{if3a, if3a, if3b, id0, ctl(0,0,0,0,0,0,1,2'd2,2'd0,0,0,0),
              ctl(0,0,1,0,1,0,0,2'd0,2'd0,0,0,0), ctl(0,0,1,0,1,0,0,2'd0,2'd0,0,0,0),
              ctl(1,0,1,0,1,0,0,2'd1,2'd0,0,0,0), if3a};
        run_seq("store_w3", 1'b1, q);

        do_reset();
        q = '{if3a, if3a, if3b, id0, ctl(0,0,0,0,0,0,1,2'd2,2'd0,0,0,0),
              ctl(0,0,1,0,1,0,0,2'd0,2'd0,0,0,0)};
        run_seq("store_abort", 1'b1, q);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("store_abort_rst", v3, zero);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("store_abort_if", v3, if3a);
        @(negedge clk);
        #1;
        check_eq("store_abort_if2", v3, if3a);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
